// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the load/store unit (master) and the data-memory responder (slave).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one word read or byte-enabled write per transaction, WAIT_CYCLES wait states.
// Optional out-of-range detection with `define DATA_MEMORY_RESPONDER_RANGE_CHECK_EN.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               reset,
  data_memory_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // state  | meaning
  // IDLE   | ready for a request
  // WAIT   | holding captured request, counting wait states
  // RESP   | commit/read, pulse resp_valid, may accept next request
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          oor_q;
  logic          oor_in;
  logic [31:0]   rdata_q;
  logic          error_q;
  logic [31:0]   rdata_live;
  logic          accept;
  logic          in_resp;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
  assign oor_in           = |bus.req_addr[31:AW+2];
  assign unused_addr_bits = ^bus.req_addr[1:0];
`else
  assign oor_in           = 1'b0;
  assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
`endif

  // Gated by reset so an aborted transaction never shows a response or accepts.
  assign in_resp        = (state == S_RESP) && !reset;
  assign bus.req_ready  = (state != S_WAIT) && !reset;
  assign accept         = bus.req_valid && bus.req_ready;
  assign rdata_live     = oor_q ? 32'd0 : mem[idx_q];
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rdata_live : rdata_q;
  assign bus.resp_error = in_resp ? oor_q : error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      oor_q    <= 1'b0;
    end else begin
      if (in_resp) begin
        rdata_q <= rdata_live;
        error_q <= oor_q;
      end
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: begin
          if (accept) begin
            wr_q    <= bus.req_write;
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            oor_q   <= oor_in;
            if (WAIT_CYCLES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= S_RESP;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Store commits in the response cycle so a load accepted in that cycle sees it.
  always_ff @(posedge clk) begin
    if (in_resp && wr_q && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder: three instances (0, 1 and 3 wait states) against a word-array model.
module tb_data_memory_responder;
  localparam int NDUT = 3;
  localparam int WAITS [NDUT] = '{0, 1, 3};

  logic clk;
  logic reset;

  logic        req_valid  [NDUT];
  logic        req_write  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [3:0]  req_be     [NDUT];
  logic        req_ready  [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_error [NDUT];

  data_memory_responder_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].req_write = req_write[g];
    assign bus[g].req_addr  = req_addr[g];
    assign bus[g].req_wdata = req_wdata[g];
    assign bus[g].req_be    = req_be[g];
    assign req_ready[g]     = bus[g].req_ready;
    assign resp_valid[g]    = bus[g].resp_valid;
    assign resp_rdata[g]    = bus[g].resp_rdata;
    assign resp_error[g]    = bus[g].resp_error;

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAITS[g])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mm [NDUT][1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Model: word index is the low 10 word-address bits; beyond 4 KB is out of range.
  function automatic bit model_oor(input logic [31:0] a);
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    return a >= 32'h1000;
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] last_rd;

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input string tag);
    int guard;
    int lat;
    int idx;
    bit exp_er;
    logic [31:0] exp_rd;
    idx    = int'(a[11:2]);
    exp_er = model_oor(a);
    exp_rd = 32'd0;
    if (wr) begin
      if (!exp_er)
        for (int i = 0; i < 4; i++)
          if (be[i]) mm[k][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_rd = exp_er ? 32'd0 : mm[k][idx];
    end
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    req_be[k]    = be;
    guard = 0;
    while (!req_ready[k] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk({tag, "_ready_timeout"}, 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!resp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(WAITS[k] + 1));
    chk({tag, "_error"}, 32'(resp_error[k]), 32'(exp_er));
    if (!wr) chk({tag, "_rdata"}, resp_rdata[k], exp_rd);
    last_rd = resp_rdata[k];
  endtask

  bit mon_ready0;
  bit ready0_dropped;
  always @(negedge clk) if (mon_ready0 && !req_ready[0]) ready0_dropped = 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] addrs [17];
    mon_ready0     = 1'b0;
    ready0_dropped = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 32'd0;
      req_wdata[k] = 32'd0; req_be[k] = 4'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'd0);
      chk("rst_error", 32'(resp_error[k]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("post_rst_ready", 32'(req_ready[k]), 32'd1);

    // Basic store/load with one wait state.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st10");
    txn(1, 1'b0, 32'h10, 32'd0, 4'h0, "ld10");
    @(negedge clk);
    chk("hold_valid", 32'(resp_valid[1]), 32'd0);
    chk("hold_rdata", resp_rdata[1], last_rd);

    // Byte lanes.
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'hF, "lane_full");
    txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "lane_part");
    txn(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "lane_none");
    txn(1, 1'b0, 32'h20, 32'd0, 4'h0, "lane_ld");
    chk("lane_value", resp_rdata[1], 32'h11BB33DD);

    // Back-to-back with zero wait states; ready must never drop.
    mon_ready0 = 1'b1;
    txn(0, 1'b1, 32'h40, 32'h5, 4'hF, "b2b_st");
    txn(0, 1'b0, 32'h40, 32'd0, 4'hF, "b2b_ld");
    chk("b2b_value", resp_rdata[0], 32'h5);
    txn(0, 1'b1, 32'h44, 32'h66, 4'hF, "b2b_st2");
    txn(0, 1'b0, 32'h44, 32'd0, 4'h0, "b2b_ld2");
    mon_ready0 = 1'b0;
    chk("b2b_ready_held", 32'(ready0_dropped), 32'd0);

    // Backpressure with three wait states: request held, address changes every cycle.
    for (int i = 0; i < 17; i++) begin
      addrs[i] = 32'h200 + 32'(4 * i);
      txn(2, 1'b1, addrs[i], $urandom, 4'hF, "bp_pre");
    end
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      req_valid[2] = (i <= 12);
      req_write[2] = 1'b0;
      req_addr[2]  = addrs[i];
      chk("bp_ready", 32'(req_ready[2]), 32'((i % 4) == 0));
      chk("bp_valid", 32'(resp_valid[2]), 32'(((i % 4) == 0) && (i > 0)));
      if (((i % 4) == 0) && (i > 0))
        chk("bp_rdata", resp_rdata[2], mm[2][int'(addrs[i-4][11:2])]);
      @(negedge clk);
    end
    req_valid[2] = 1'b0;

    // Reset during the wait state of a store aborts it.
    txn(1, 1'b1, 32'h80, 32'h12345678, 4'hF, "abort_pre");
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h80;
    req_wdata[1] = 32'h77; req_be[1] = 4'hF;
    chk("abort_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_valid", 32'(resp_valid[1]), 32'd0);
      chk("abort_ready_rst", 32'(req_ready[1]), 32'd0);
      chk("abort_rdata", resp_rdata[1], 32'd0);
      chk("abort_error", 32'(resp_error[1]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_post_ready", 32'(req_ready[1]), 32'd1);
    chk("abort_post_valid", 32'(resp_valid[1]), 32'd0);
    txn(1, 1'b0, 32'h80, 32'd0, 4'h0, "abort_ld");

    // Out-of-range store, then read word 0.
    txn(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "oor_pre");
    txn(1, 1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, "oor_st");
    txn(1, 1'b0, 32'h0, 32'd0, 4'h0, "oor_ld");

    // Randomized traffic on a small window, occasionally with high address bits set.
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 16; w++) txn(k, 1'b1, 32'(4 * w), $urandom, 4'hF, "rnd_pre");
      for (int t = 0; t < 40; t++) begin
        a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
        txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
